vec_exec_unit: RTL

Multi-lane vector execute unit for the pipelined 16-bit CPU. It receives a decoded vector-arithmetic command (VADD/VSUB/VMUL/VMIN/VMAX) plus two operand vectors and processes LANES elements per cycle over VLEN/LANES beats. Per-vector status flags are returned over a valid/ready result handshake. It sits beside the scalar execute stage; the writeback stage consumes its results.

---
 rtl/vec_pkg.sv | 26 ++
 rtl/vec_lane_alu.sv | 54 +++++
 rtl/vec_exec_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute unit: opcodes, FSM states and
// saturation-bound helpers.
package vec_pkg;

  localparam logic [2:0] VOP_ADD = 3'd0;
  localparam logic [2:0] VOP_SUB = 3'd1;
  localparam logic [2:0] VOP_MUL = 3'd2;
  localparam logic [2:0] VOP_MIN = 3'd3;
  localparam logic [2:0] VOP_MAX = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} vecState_t;

  // Signed bound for a dataW-bit element, returned in 64-bit two's complement;
  // callers keep the low dataW bits.
  function automatic logic [63:0] satBound(input int dataW, input logic upper);
    logic [63:0] lim;
    lim = 64'd1 << (dataW - 1);
    if (upper) return lim - 64'd1;
    return (~lim) + 64'd1;
  endfunction

  function automatic logic isLegalOp(input logic [2:0] op);
    return op <= VOP_MAX;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One-element combinational ALU: signed add/sub/mul with wrap or saturation,
// plus signed min/max. Illegal opcodes produce zero with no overflow.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter bit SAT    = 1'b0
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] HI = DATA_W'(satBound(DATA_W, 1'b1));
  localparam logic [DATA_W-1:0] LO = DATA_W'(satBound(DATA_W, 1'b0));

  logic signed [DATA_W:0]     sum, diff;
  logic signed [2*DATA_W-1:0] prod;
  logic                       sumOvf, diffOvf, mulOvf;

  assign sum  = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
  assign diff = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
  assign prod = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));

  // A result fits when every bit above the element's sign bit matches it.
  assign sumOvf  = sum[DATA_W] ^ sum[DATA_W-1];
  assign diffOvf = diff[DATA_W] ^ diff[DATA_W-1];
  assign mulOvf  = ~((&prod[2*DATA_W-1:DATA_W-1]) | ~(|prod[2*DATA_W-1:DATA_W-1]));

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      VOP_ADD: begin
        ovf    = sumOvf;
        result = (SAT && sumOvf) ? (sum[DATA_W] ? LO : HI) : sum[DATA_W-1:0];
      end
      VOP_SUB: begin
        ovf    = diffOvf;
        result = (SAT && diffOvf) ? (diff[DATA_W] ? LO : HI) : diff[DATA_W-1:0];
      end
      VOP_MUL: begin
        ovf    = mulOvf;
        result = (SAT && mulOvf) ? (prod[2*DATA_W-1] ? LO : HI) : prod[DATA_W-1:0];
      end
      VOP_MIN: result = ($signed(a) < $signed(b)) ? a : b;
      VOP_MAX: result = ($signed(a) > $signed(b)) ? a : b;
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-lane vector execute unit: latches a command, runs LANES elements per
// beat through an ALU array, accumulates zero/overflow flags, then holds the result.
module vec_exec_unit
  import vec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int VLEN   = 16,
  parameter int LANES  = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [VLEN*DATA_W-1:0] cmd_a,
  input  logic [VLEN*DATA_W-1:0] cmd_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VLEN*DATA_W-1:0] res_data,
  output logic                   res_zero,
  output logic                   res_ovf,
  output logic                   res_err
);

  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (VLEN > 1) ? $clog2(VLEN) : 1;

  vecState_t                    state;
  logic [2:0]                   opReg;
  logic [BW-1:0]                beat;
  logic [VLEN-1:0][DATA_W-1:0]  aVec, bVec, resVec;
  logic [LANES-1:0][IW-1:0]     laneIdx;
  logic [LANES-1:0][DATA_W-1:0] laneA, laneB, laneRes;
  logic [LANES-1:0]             laneOvf, laneZero;

  assign res_data = resVec;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign laneIdx[l]  = IW'(beat * LANES + l);
    assign laneA[l]    = aVec[laneIdx[l]];
    assign laneB[l]    = bVec[laneIdx[l]];
    assign laneZero[l] = ~|laneRes[l];

    vec_lane_alu #(.DATA_W(DATA_W), .SAT(SAT)) u_alu (
      .op     (opReg),
      .a      (laneA[l]),
      .b      (laneB[l]),
      .result (laneRes[l]),
      .ovf    (laneOvf[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opReg     <= '0;
      beat      <= '0;
      aVec      <= '0;
      bVec      <= '0;
      resVec    <= '0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_zero  <= 1'b0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          opReg     <= cmd_op;
          aVec      <= cmd_a;
          bVec      <= cmd_b;
          beat      <= '0;
          res_zero  <= 1'b1;
          res_ovf   <= 1'b0;
          if (isLegalOp(cmd_op)) begin
            res_err <= 1'b0;
            state   <= RUN;
          end else begin
            // Illegal ops skip RUN; DONE raises res_valid one cycle later.
            res_err <= 1'b1;
            resVec  <= '0;
            state   <= DONE;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) resVec[laneIdx[l]] <= laneRes[l];
          res_zero <= res_zero & (&laneZero);
          res_ovf  <= res_ovf | (|laneOvf);
          beat     <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) begin
            beat      <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          res_valid <= 1'b1;
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
